// File: rtl/branch_predictor_ctrl_pkg.sv
// Shared encodings for the branch prediction lookup table controller.
package branch_predictor_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 16;

    // 2-bit confidence counter: MSB is the taken prediction
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        BP_STATE_IDLE  = 1'b0,
        BP_STATE_SWEEP = 1'b1
    } bp_state_e;

    // Freshly allocated entries start weakly taken
    localparam ctr_e CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/sat_counter2.sv
// Next-value logic for a 2-bit saturating up/down confidence counter.
module sat_counter2
    import branch_predictor_ctrl_pkg::*;
(
    input  ctr_e ctr,
    input  logic up,
    output ctr_e next
);

    // Step toward strong taken on up, toward strong not-taken otherwise
    always_comb begin
        next = ctr;
        if (up) begin
            if (ctr != CTR_ST)
                next = ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != CTR_SNT)
                next = ctr_e'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Fully-associative branch prediction table: same-cycle lookup, EX-stage
// training/allocation, and a one-entry-per-cycle invalidate sweep.
module branch_predictor_ctrl
    import branch_predictor_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned AW      = ADDR_WIDTH,
    parameter int unsigned IDXW    = 3
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] lookup_pc,
    output logic          predict_taken,
    output logic [AW-1:0] predict_target,
    input  logic          update_valid,
    input  logic [AW-1:0] update_pc,
    input  logic [AW-1:0] update_target,
    input  logic          update_taken,
    input  logic          clear,
    output logic          busy
);

    logic          valid  [ENTRIES];
    ctr_e          ctr    [ENTRIES];
    ctr_e          ctr_nx [ENTRIES];
    logic [AW-1:0] tag    [ENTRIES];
    logic [AW-1:0] target [ENTRIES];

    bp_state_e      state;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] rr;

    logic            lk_hit;
    logic [IDXW-1:0] lk_idx;
    logic            up_hit;
    logic [IDXW-1:0] up_idx;
    logic            free_found;
    logic [IDXW-1:0] free_idx;
    logic [IDXW-1:0] victim;

    // Per-entry counter next values, trained by the resolved outcome
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        sat_counter2 u_sat (
            .ctr  (ctr[g]),
            .up   (update_taken),
            .next (ctr_nx[g])
        );
    end

    // Tag match for the fetch PC and for the resolved branch PC
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        up_hit = 1'b0;
        up_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tag[i] == lookup_pc) begin
                lk_hit = 1'b1;
                lk_idx = IDXW'(i);
            end
            if (valid[i] && tag[i] == update_pc) begin
                up_hit = 1'b1;
                up_idx = IDXW'(i);
            end
        end
    end

    // Victim choice: lowest-index invalid entry, else round-robin pointer
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
        victim = free_found ? free_idx : rr;
    end

    // Prediction is suppressed for the whole sweep
    always_comb begin
        predict_taken  = 1'b0;
        predict_target = '0;
        if (state == BP_STATE_IDLE && lk_hit) begin
            predict_taken = ctr[lk_idx][1];
            if (ctr[lk_idx][1])
                predict_target = target[lk_idx];
        end
    end

    assign busy = (state == BP_STATE_SWEEP);

    // Table state and sweep FSM; an update in the clear cycle lands before the sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                ctr[i]    <= CTR_SNT;
                tag[i]    <= '0;
                target[i] <= '0;
            end
            rr    <= '0;
            idx   <= '0;
            state <= BP_STATE_IDLE;
        end else begin
            case (state)
                BP_STATE_IDLE: begin
                    if (update_valid) begin
                        if (up_hit) begin
                            ctr[up_idx] <= ctr_nx[up_idx];
                            if (update_taken)
                                target[up_idx] <= update_target;
                        end else if (update_taken) begin
                            valid[victim]  <= 1'b1;
                            tag[victim]    <= update_pc;
                            target[victim] <= update_target;
                            ctr[victim]    <= CTR_ALLOC;
                            if (!free_found)
                                rr <= rr + IDXW'(1);
                        end
                    end
                    if (clear) begin
                        state <= BP_STATE_SWEEP;
                        idx   <= '0;
                    end
                end
                BP_STATE_SWEEP: begin
                    valid[idx] <= 1'b0;
                    ctr[idx]   <= CTR_SNT;
                    idx        <= idx + IDXW'(1);
                    if (idx == IDXW'(ENTRIES - 1)) begin
                        state <= BP_STATE_IDLE;
                        rr    <= '0;
                    end
                end
                default: state <= BP_STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Self-checking bench for branch_predictor_ctrl against a behavioural table model.
module tb_branch_predictor_ctrl;

    localparam int N = 8;

    logic        clk;
    logic        reset;
    logic [15:0] lookup_pc;
    logic        predict_taken;
    logic [15:0] predict_target;
    logic        update_valid;
    logic [15:0] update_pc;
    logic [15:0] update_target;
    logic        update_taken;
    logic        clear;
    logic        busy;

    int checks = 0;
    int errors = 0;

    branch_predictor_ctrl #(.ENTRIES(8), .AW(16), .IDXW(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_target  (update_target),
        .update_taken   (update_taken),
        .clear          (clear),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: table of entries with integer confidence 0..3
    bit m_valid [N];
    int m_tag   [N];
    int m_tgt   [N];
    int m_cnt   [N];
    int m_rr;
    bit m_sweep;
    int m_sidx;

    logic        obs_taken;
    logic [15:0] obs_target;
    logic        obs_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
        end
        m_rr = 0; m_sweep = 0; m_sidx = 0;
    endfunction

    function automatic void model_predict(input int pc, output bit tk, output int tg);
        tk = 0; tg = 0;
        if (m_sweep) return;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == pc && m_cnt[i] >= 2) begin
                tk = 1; tg = m_tgt[i];
            end
    endfunction

    function automatic void model_clock(input bit uv, input int upc, input int utgt, input bit utk, input bit clr);
        int h;
        int v;
        if (m_sweep) begin
            m_valid[m_sidx] = 0;
            m_cnt[m_sidx] = 0;
            m_sidx++;
            if (m_sidx == N) begin
                m_sweep = 0; m_rr = 0;
            end
            return;
        end
        if (uv) begin
            h = -1;
            for (int i = 0; i < N; i++)
                if (m_valid[i] && m_tag[i] == upc) h = i;
            if (h >= 0) begin
                if (utk) begin
                    m_cnt[h] = (m_cnt[h] < 3) ? m_cnt[h] + 1 : 3;
                    m_tgt[h] = utgt;
                end else begin
                    m_cnt[h] = (m_cnt[h] > 0) ? m_cnt[h] - 1 : 0;
                end
            end else if (utk) begin
                v = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (!m_valid[i]) v = i;
                if (v < 0) begin
                    v = m_rr;
                    m_rr = (m_rr + 1) % N;
                end
                m_valid[v] = 1; m_tag[v] = upc; m_tgt[v] = utgt; m_cnt[v] = 2;
            end
        end
        if (clr) begin
            m_sweep = 1; m_sidx = 0;
        end
    endfunction

    // One cycle: drive after negedge, compare mid-cycle, advance model at posedge
    task automatic step(input logic [15:0] lpc, input logic uv, input logic [15:0] upc,
                        input logic [15:0] utgt, input logic utk, input logic clr);
        bit e_tk;
        int e_tg;
        lookup_pc = lpc; update_valid = uv; update_pc = upc;
        update_target = utgt; update_taken = utk; clear = clr;
        #1;
        model_predict(int'(lpc), e_tk, e_tg);
        check_eq("predict_taken", 32'(predict_taken), 32'(e_tk));
        check_eq("predict_target", 32'(predict_target), 32'(e_tg));
        check_eq("busy", 32'(busy), 32'(m_sweep));
        obs_taken = predict_taken; obs_target = predict_target; obs_busy = busy;
        @(posedge clk);
        model_clock(uv, int'(upc), int'(utgt), utk, clr);
        @(negedge clk);
    endtask

    task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
        step(pc, 1'b1, pc, tgt, tk, 1'b0);
    endtask

    task automatic look(input logic [15:0] pc);
        step(pc, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        update_valid = 1'b0; clear = 1'b0; lookup_pc = '0;
        update_pc = '0; update_target = '0; update_taken = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        reset = 1'b1;
        lookup_pc = '0; update_valid = 1'b0; update_pc = '0;
        update_target = '0; update_taken = 1'b0; clear = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        look(16'h0010);
        check_eq("rst_taken", 32'(obs_taken), 32'd0);
        check_eq("rst_target", 32'(obs_target), 32'd0);
        check_eq("rst_busy", 32'(obs_busy), 32'd0);

        // Allocate and train
        upd(16'h0010, 16'h0040, 1'b1);
        look(16'h0010);
        check_eq("alloc_taken", 32'(obs_taken), 32'd1);
        check_eq("alloc_target", 32'(obs_target), 32'h0040);
        upd(16'h0010, 16'h1234, 1'b0);
        upd(16'h0010, 16'h1234, 1'b0);
        look(16'h0010);
        check_eq("snt_taken", 32'(obs_taken), 32'd0);
        upd(16'h0010, 16'h0040, 1'b1);
        look(16'h0010);
        check_eq("wnt_taken", 32'(obs_taken), 32'd0);

        // Same-cycle update and lookup: old state now, new state next cycle
        step(16'h0010, 1'b1, 16'h0010, 16'h0050, 1'b1, 1'b0);
        check_eq("same_cyc_old", 32'(obs_taken), 32'd0);
        look(16'h0010);
        check_eq("same_cyc_new", 32'(obs_taken), 32'd1);
        check_eq("same_cyc_tgt", 32'(obs_target), 32'h0050);

        // Saturation
        for (int i = 0; i < 4; i++) upd(16'h0010, 16'h0060, 1'b1);
        upd(16'h0010, 16'h0000, 1'b0);
        look(16'h0010);
        check_eq("sat_taken", 32'(obs_taken), 32'd1);
        check_eq("sat_target", 32'(obs_target), 32'h0060);

        // Replacement
        do_reset();
        for (int i = 0; i < 8; i++) upd(16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b1);
        upd(16'h0200, 16'h2000, 1'b1);
        look(16'h0100);
        check_eq("repl0_evict", 32'(obs_taken), 32'd0);
        look(16'h0200);
        check_eq("repl0_new", 32'(obs_target), 32'h2000);
        upd(16'h0201, 16'h2001, 1'b1);
        look(16'h0101);
        check_eq("repl1_evict", 32'(obs_taken), 32'd0);
        look(16'h0102);
        check_eq("repl1_keep", 32'(obs_target), 32'h1002);
        upd(16'h0300, 16'h3000, 1'b0);
        look(16'h0300);
        check_eq("miss_nt", 32'(obs_taken), 32'd0);
        upd(16'h0202, 16'h2002, 1'b1);
        look(16'h0102);
        check_eq("rr_after_nt", 32'(obs_taken), 32'd0);

        // Sweep
        do_reset();
        for (int i = 0; i < 3; i++) upd(16'h0400 + 16'(i), 16'h4000 + 16'(i), 1'b1);
        step(16'h0400, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) step(16'h0400, 1'b1, 16'h0500, 16'h5000, 1'b1, 1'b1);
            else look(16'h0400);
            if (obs_busy) busy_cnt++;
            if (i <= 8) check_eq("sweep_no_pred", 32'(obs_taken), 32'd0);
        end
        check_eq("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
        look(16'h0500);
        check_eq("sweep_upd_dropped", 32'(obs_taken), 32'd0);
        for (int i = 0; i < 3; i++) begin
            look(16'h0400 + 16'(i));
            check_eq("sweep_cleared", 32'(obs_taken), 32'd0);
        end
        for (int i = 0; i < 9; i++) upd(16'h0600 + 16'(i), 16'h6000 + 16'(i), 1'b1);
        look(16'h0600);
        check_eq("post_sweep_rr0", 32'(obs_taken), 32'd0);
        look(16'h0601);
        check_eq("post_sweep_keep", 32'(obs_taken), 32'd1);

        // Reset during sweep cycle 4
        step(16'h0601, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) look(16'h0601);
        lookup_pc = 16'h0601;
        reset = 1'b1;
        #1;
        check_eq("midsweep_rst_busy", 32'(busy), 32'd0);
        check_eq("midsweep_rst_pred", 32'(predict_taken), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            look(16'h0600 + 16'(i));
            check_eq("midsweep_rst_empty", 32'(obs_taken), 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(16'h0700 + 16'($urandom_range(0, 11)),
                 1'($urandom_range(0, 1)),
                 16'h0700 + 16'($urandom_range(0, 11)),
                 16'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
